// File: rtl/arm_fetch_stage.sv
// arm_fetch_stage: instruction-fetch stage in front of arm_instruction_memory.
// Owns the PC, drives the memory byte address and registers the returned word
// into the IF/ID register with a valid/ready handshake toward decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall performance counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset; no capture, pc holds
// FETCH | normal operation, one capture per cycle when decode advances
// STALL | IF/ID holds a word decode has not taken; pc and IF/ID hold
module arm_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_aligned;
  logic              adv;

  // Memory address is the PC itself, live in every state.
  assign imem_addr  = pc;
  assign pc_inc     = pc + STEP;
  assign br_aligned = br_target & ALIGN_MASK;
  assign adv        = !id_valid || id_ready;

  // Fetch FSM: pc, IF/ID register and state, with branch > flush > advance priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      id_pc_next <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH, STALL: begin
          if (br_taken) begin
            // Word fetched this cycle is dropped; the redirect costs one bubble.
            pc       <= br_aligned;
            id_valid <= 1'b0;
            state    <= FETCH;
          end else if (flush) begin
            // pc is left alone so the same address is refetched next cycle.
            id_valid <= 1'b0;
            state    <= FETCH;
          end else if (adv) begin
            id_instr   <= imem_instr;
            id_pc      <= pc;
            id_pc_next <= pc_inc;
            id_valid   <= 1'b1;
            pc         <= pc_inc;
            state      <= FETCH;
          end else begin
            state <= STALL;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: captures, and stall cycles not resolved by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (state == FETCH || state == STALL) begin
      if (!br_taken && !flush && adv) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (state == STALL && !br_taken && !flush) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Bench for arm_fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_arm_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic        m_boot;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idnext;
  logic        m_stalled;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;

  arm_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .flush      (flush),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_next (id_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic rdy);
    rst = r; br_taken = br; br_target = tgt; flush = fl; id_ready = rdy;
    if (r) begin
      m_boot = 1'b1; m_pc = 32'h0; m_valid = 1'b0; m_instr = '0;
      m_idpc = '0; m_idnext = '0; m_stalled = 1'b0;
      m_fetch_cnt = '0; m_stall_cnt = '0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (m_stalled && !br && !fl) m_stall_cnt = m_stall_cnt + 1;
      if (br) begin
        m_pc = {tgt[31:2], 2'b00};
        m_valid = 1'b0;
        m_stalled = 1'b0;
      end else if (fl) begin
        m_valid = 1'b0;
        m_stalled = 1'b0;
      end else if (!m_valid || rdy) begin
        m_instr = mem_word(m_pc);
        m_idpc = m_pc;
        m_idnext = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
        m_stalled = 1'b0;
        m_fetch_cnt = m_fetch_cnt + 1;
      end else begin
        m_stalled = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("imem_addr",  imem_addr,  m_pc);
    check("id_valid",   {31'b0, id_valid}, {31'b0, m_valid});
    check("id_instr",   id_instr,   m_instr);
    check("id_pc",      id_pc,      m_idpc);
    check("id_pc_next", id_pc_next, m_idnext);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
    check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
  endtask

  initial begin
    logic [31:0] held_instr;
    rst = 1'b1; br_taken = 1'b0; br_target = '0; flush = 1'b0; id_ready = 1'b1;
    m_boot = 1'b1; m_pc = '0; m_valid = 1'b0; m_instr = '0; m_idpc = '0;
    m_idnext = '0; m_stalled = 1'b0; m_fetch_cnt = '0; m_stall_cnt = '0;

    // Reset for two cycles, then BOOT and sequential fetch 0,4,8.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("reset_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_valid", {31'b0, id_valid}, 32'h0);
    step(0, 0, 0, 0, 1);
    check("seq_pc0", id_pc, 32'h0);
    step(0, 0, 0, 0, 1);
    check("seq_pc4", id_pc, 32'h4);
    step(0, 0, 0, 0, 1);
    check("seq_pc8", id_pc, 32'h8);

    // Back-pressure for three cycles while id_pc=8.
    held_instr = id_instr;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("stall_pc", id_pc, 32'h8);
      check("stall_instr", id_instr, held_instr);
      check("stall_addr", imem_addr, 32'hC);
    end
    step(0, 0, 0, 0, 1);
    check("release_pc", id_pc, 32'hC);

    // Branch to 0x2B while fetching at 16.
    check("pre_branch_addr", imem_addr, 32'h10);
    step(0, 1, 32'h2B, 0, 1);
    check("branch_bubble", {31'b0, id_valid}, 32'h0);
    check("branch_addr", imem_addr, 32'h28);
    step(0, 0, 0, 0, 1);
    check("branch_target_pc", id_pc, 32'h28);

    // Flush at pc=24, then flush together with a branch to 40.
    step(0, 1, 32'h18, 0, 1);
    step(0, 0, 0, 1, 1);
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    check("flush_addr", imem_addr, 32'h18);
    step(0, 0, 0, 0, 1);
    check("flush_refetch", id_pc, 32'h18);
    step(0, 1, 32'h28, 1, 1);
    check("brfl_addr", imem_addr, 32'h28);
    step(0, 0, 0, 0, 1);
    check("brfl_pc", id_pc, 32'h28);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFF, 0, 1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    check("wrap_pc_next", id_pc_next, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset in the middle of a stall.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_stall_valid", {31'b0, id_valid}, 32'h0);
    check("rst_stall_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, b, f, y;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      b = ($urandom_range(0, 99) < 10);
      f = ($urandom_range(0, 99) < 10);
      y = ($urandom_range(0, 99) < 65);
      t = $urandom;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step(r, b, t, f, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
